cascade_sequencer: RTL and testbench
====================================

// Module: cascade_sequencer
// PURPOSE
//  Clocked, parametrised cascade/INTA sequencer for the 8259A PIC. Sits between control logic and CAS pins.
//  Master: drives CAS with the acknowledged IR ID and decides who supplies the vector.
//  Slave: decodes CAS against its ICW3 ID.
//  Tracks the full 8080 (3-pulse) or 8086 (2-pulse) INTA sequence and reports completion.
// PARAMETERS
//  CAS_W      3    cascade line width; N_IR = 2**CAS_W IR inputs / slave slots
//  TO_CYCLES  255  timeout in clk cycles between INTA edges (used only with CASCADE_TIMEOUT_EN)
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  sp_en        in   1      1 = MASTER, 0 = SLAVE; latched at first INTA fall
//  icw3         in   N_IR   master: bit i = 1 means slave on IR i; slave: [CAS_W-1:0] = own ID
//  mode_8086    in   1      1 = 2-pulse 8086 sequence, 0 = 3-pulse 8080; latched at first fall
//  int_pending  in   1      control logic has INT asserted
//  ack_ir       in   CAS_W  highest-priority IR being acknowledged; sampled at first fall
//  inta_n       in   1      INTA strobe, active low, already synchronised to clk
//  cas_i        in   CAS_W  CAS pins, input side
//  cas_o        out  CAS_W  CAS drive value (master only)
//  cas_oe       out  1      CAS tri-state enable
//  vec_oe       out  1      this device drives the data bus during the current pulse
//  vec_phase    out  2      byte index: 0 = CALL opcode, 1 = vector/low addr, 2 = high addr
//  selected     out  1      slave: CAS matched own ID in this sequence; master: always 0
//  ack_done     out  1      1-cycle pulse at end of the last INTA pulse
//  seq_err      out  1      1-cycle pulse when the sequence is aborted by timeout
// BEHAVIOUR
//  - Reset: state IDLE; cas_o = 0; cas_oe, vec_oe, selected, ack_done, seq_err = 0; vec_phase = 0; inta_q = 1.
//  - Edge detect: fall = inta_q & ~inta_n; rise = ~inta_q & inta_n. All outputs are registered, 1-cycle latency after detection.
//  - FSM states: IDLE -> P1 -> P2 -> [P3 when 8080] -> IDLE.
//    Advance on each fall. Leave the last state on rise, which pulses ack_done.
//  - First fall in IDLE latches sp_q, m86_q, ir_q and hit_q.
//    ir_q = ack_ir, or N_IR-1 if int_pending = 0 (spurious, IR7-style). hit_q = icw3[ir_q].
//  - Master, hit_q = 1: cas_o = ir_q and cas_oe = 1 from cycle after first fall until cycle after final rise.
//  - Master, hit_q = 0: cas_oe stays 0.
//  - vec_phase counts 0 (P1), 1 (P2), 2 (P3) in 8080 mode.
//    8086 mode: P1 carries no data, P2 is phase 1.
//  - Master vec_oe: 8080 P1 always (CALL). Vector pulses only when hit_q = 0. Never in 8086 P1.
//  - Slave: cas_oe = 0 always. Cycle after first fall, selected <= (cas_i == icw3[CAS_W-1:0]).
//    Slave vec_oe only during vector pulses and only if selected. Never in 8080 P1.
//  - vec_oe asserts the cycle after a fall and deasserts the cycle after the matching rise.
//  - selected clears when the FSM returns to IDLE.
//  - Simultaneous events:
//    Fall while already in the last state: ignored.
//    sp_en, mode_8086, ack_ir changes mid-sequence: ignored (latched copies used).
//    int_pending deasserting mid-sequence: no effect.
//  - rst_n asserted mid-sequence: immediate return to reset values, no ack_done.
// CONFIGURATION
//  CASCADE_TIMEOUT_EN defined:
//    Counter clears on every edge; it counts cycles while not IDLE.
//    Reaching TO_CYCLES aborts to IDLE: seq_err pulses 1 cycle; cas_oe, vec_oe, selected drop; no ack_done.
//  CASCADE_TIMEOUT_EN undefined: no counter, seq_err tied 0, TO_CYCLES unused.
// STRUCTURE
//  cascade_pkg: MASTER/SLAVE constants, FSM state enum, vec_phase encodings (PH_CALL, PH_LO, PH_HI).
//  Sub-module inta_edge_detect: inta_q register plus fall/rise outputs, reset to idle-high.
// TESTING
//  1. Master, 8086, icw3 = 8'h00, ack_ir = 5: two pulses.
//     Expect cas_oe = 0; vec_oe only in P2 with vec_phase = 1; ack_done once after 2nd rise.
//  2. Master, 8080, icw3 = 8'h20, ack_ir = 5: three pulses.
//     Expect cas_o = 3'd5, cas_oe high throughout; vec_oe only in P1 (phase 0).
//  3. Slave, 8080, icw3[2:0] = 3'd2, cas_i = 2: selected = 1; vec_oe in P2/P3 (phase 1, 2).
//     With cas_i = 3: selected = 0, vec_oe never asserts.
//  4. Master, int_pending = 0 at first fall, icw3 = 8'h80: ir_q = 7; cas_o = 7, cas_oe = 1 (spurious path).
//  5. rst_n low during P2: next cycle all outputs 0, state IDLE, no ack_done. A new sequence then runs normally.
//  6. [CASCADE_TIMEOUT_EN] TO_CYCLES = 16, inta_n held low after first fall: seq_err pulses at cycle 16, outputs drop.

Source files
------------

// File: rtl/cascade_pkg.sv
// cascade_pkg
// Shared definitions for the 8259A cascade/INTA sequencer:
//   MASTER / SLAVE  values of the sp_en strap
//   state_t         INTA sequence FSM states
//   PH_CALL/LO/HI   vec_phase encodings (byte index on the data bus)
package cascade_pkg;

    localparam logic MASTER = 1'b1;
    localparam logic SLAVE  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_P1   = 2'd1,
        ST_P2   = 2'd2,
        ST_P3   = 2'd3
    } state_t;

    localparam logic [1:0] PH_CALL = 2'd0;
    localparam logic [1:0] PH_LO   = 2'd1;
    localparam logic [1:0] PH_HI   = 2'd2;

endpackage

// File: rtl/cascade_sequencer_inta_edge_detect.sv
// inta_edge_detect
// Registers the (already synchronised) INTA strobe and flags its edges.
// The register resets to the idle-high level, so an INTA that is low when
// reset is released is seen as a falling edge.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   inta_n  in   INTA strobe, active low
//   fall    out  inta_n went 1 -> 0 (combinational, valid this cycle)
//   rise    out  inta_n went 0 -> 1 (combinational, valid this cycle)
module inta_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic inta_n,
    output logic fall,
    output logic rise
);

    logic inta_q;
    logic inta_d;

    always_comb begin
        inta_d = inta_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inta_q <= 1'b1;
        end else begin
            inta_q <= inta_d;
        end
    end

    assign fall = inta_q & ~inta_n;
    assign rise = ~inta_q & inta_n;

endmodule

// File: rtl/cascade_sequencer.sv
// cascade_sequencer
// Cascade / INTA sequencer of the 8259A PIC. As master it drives CAS with
// the acknowledged IR and decides who supplies the vector; as slave it
// decodes CAS against its own ID. Follows the 3-pulse 8080 or 2-pulse 8086
// INTA sequence and pulses ack_done when the last pulse ends.
// Optional feature: define CASCADE_TIMEOUT_EN to abort a stalled sequence
// after TO_CYCLES clocks without an INTA edge (seq_err pulse).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   sp_en        1 = master, 0 = slave (latched at first INTA fall)
//   icw3         master: slave-present mask; slave: [CAS_W-1:0] own ID
//   mode_8086    1 = 2-pulse sequence, 0 = 3-pulse (latched at first fall)
//   int_pending  INT asserted; 0 at first fall selects the spurious IR
//   ack_ir       IR being acknowledged (sampled at first fall)
//   inta_n       INTA strobe, active low, synchronised
//   cas_i        CAS pins input
//   cas_o/cas_oe CAS drive value and enable (master only)
//   vec_oe       this device drives the data bus in the current pulse
//   vec_phase    byte index 0 = CALL, 1 = vector/low, 2 = high
//   selected     slave matched its ID in this sequence
//   ack_done     1-cycle pulse at end of the last INTA pulse
//   seq_err      1-cycle pulse on timeout abort
module cascade_sequencer
    import cascade_pkg::*;
#(
    parameter int CAS_W     = 3,
    parameter int TO_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sp_en,
    input  logic [2**CAS_W-1:0]   icw3,
    input  logic                  mode_8086,
    input  logic                  int_pending,
    input  logic [CAS_W-1:0]      ack_ir,
    input  logic                  inta_n,
    input  logic [CAS_W-1:0]      cas_i,
    output logic [CAS_W-1:0]      cas_o,
    output logic                  cas_oe,
    output logic                  vec_oe,
    output logic [1:0]            vec_phase,
    output logic                  selected,
    output logic                  ack_done,
    output logic                  seq_err
);

    logic fall;
    logic rise;

    inta_edge_detect u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .inta_n (inta_n),
        .fall   (fall),
        .rise   (rise)
    );

    state_t           state_q, state_d;
    logic             sp_q, sp_d;
    logic             m86_q, m86_d;
    logic [CAS_W-1:0] ir_q, ir_d;
    logic             hit_q, hit_d;
    logic [CAS_W-1:0] cas_o_q, cas_o_d;
    logic             cas_oe_q, cas_oe_d;
    logic             vec_oe_q, vec_oe_d;
    logic [1:0]       vec_phase_q, vec_phase_d;
    logic             selected_q, selected_d;
    logic             ack_done_q, ack_done_d;

    logic [CAS_W-1:0] ir_new;
    logic             vector_oe;
    logic             finish;
    logic             abort;

`ifdef CASCADE_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            seq_err_q, seq_err_d;
`endif

    // Next-state logic. Sequence context is latched at the first fall so
    // later changes on sp_en / mode_8086 / ack_ir cannot disturb it. Who
    // drives a vector pulse: the master when no slave sits on the IR, or
    // the slave whose ID matched CAS.
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        m86_d       = m86_q;
        ir_d        = ir_q;
        hit_d       = hit_q;
        cas_o_d     = cas_o_q;
        cas_oe_d    = cas_oe_q;
        vec_oe_d    = vec_oe_q;
        vec_phase_d = vec_phase_q;
        selected_d  = selected_q;
        ack_done_d  = 1'b0;
        finish      = 1'b0;
        abort       = 1'b0;

        // Without a pending INT the acknowledge is spurious and uses the
        // lowest-priority IR, as the real part does.
        ir_new    = int_pending ? ack_ir : {CAS_W{1'b1}};
        vector_oe = (sp_q == MASTER) ? ~hit_q : selected_q;

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d     = ST_P1;
                    sp_d        = sp_en;
                    m86_d       = mode_8086;
                    ir_d        = ir_new;
                    hit_d       = icw3[ir_new];
                    vec_phase_d = PH_CALL;
                    if (sp_en == MASTER) begin
                        cas_oe_d   = icw3[ir_new];
                        cas_o_d    = icw3[ir_new] ? ir_new : '0;
                        vec_oe_d   = ~mode_8086;
                        selected_d = 1'b0;
                    end else begin
                        cas_oe_d   = 1'b0;
                        cas_o_d    = '0;
                        vec_oe_d   = 1'b0;
                        selected_d = (cas_i == icw3[CAS_W-1:0]);
                    end
                end
            end
            ST_P1: begin
                if (rise) begin
                    vec_oe_d = 1'b0;
                end else if (fall) begin
                    state_d     = ST_P2;
                    vec_phase_d = PH_LO;
                    vec_oe_d    = vector_oe;
                end
            end
            ST_P2: begin
                if (rise) begin
                    if (m86_q) begin
                        finish = 1'b1;
                    end else begin
                        vec_oe_d = 1'b0;
                    end
                end else if (fall && !m86_q) begin
                    state_d     = ST_P3;
                    vec_phase_d = PH_HI;
                    vec_oe_d    = vector_oe;
                end
            end
            ST_P3: begin
                if (rise) begin
                    finish = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef CASCADE_TIMEOUT_EN
        // Any INTA edge restarts the watchdog; it only runs mid-sequence.
        cnt_d = '0;
        if (state_q != ST_IDLE && !fall && !rise) begin
            if (cnt_q == TO_W'(TO_CYCLES - 1)) begin
                abort = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        seq_err_d = abort;
`endif

        if (finish || abort) begin
            state_d     = ST_IDLE;
            cas_o_d     = '0;
            cas_oe_d    = 1'b0;
            vec_oe_d    = 1'b0;
            vec_phase_d = PH_CALL;
            selected_d  = 1'b0;
            ack_done_d  = finish;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sp_q        <= SLAVE;
            m86_q       <= 1'b0;
            ir_q        <= '0;
            hit_q       <= 1'b0;
            cas_o_q     <= '0;
            cas_oe_q    <= 1'b0;
            vec_oe_q    <= 1'b0;
            vec_phase_q <= PH_CALL;
            selected_q  <= 1'b0;
            ack_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            m86_q       <= m86_d;
            ir_q        <= ir_d;
            hit_q       <= hit_d;
            cas_o_q     <= cas_o_d;
            cas_oe_q    <= cas_oe_d;
            vec_oe_q    <= vec_oe_d;
            vec_phase_q <= vec_phase_d;
            selected_q  <= selected_d;
            ack_done_q  <= ack_done_d;
        end
    end

`ifdef CASCADE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            seq_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

    assign cas_o     = cas_o_q;
    assign cas_oe    = cas_oe_q;
    assign vec_oe    = vec_oe_q;
    assign vec_phase = vec_phase_q;
    assign selected  = selected_q;
    assign ack_done  = ack_done_q;

endmodule

// File: tb/tb_cascade_sequencer.sv
// tb_cascade_sequencer
// Directed bench for cascade_sequencer: master/slave, 8080/8086 sequences,
// spurious acknowledge, mid-sequence reset and (with CASCADE_TIMEOUT_EN)
// the timeout abort. Inputs change 1 time unit after a rising edge; outputs
// are sampled at that same point after the following edge.
module tb_cascade_sequencer;

`ifdef CASCADE_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 255;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sp_en;
    logic [7:0] icw3;
    logic       mode_8086;
    logic       int_pending;
    logic [2:0] ack_ir;
    logic       inta_n;
    logic [2:0] cas_i;
    logic [2:0] cas_o;
    logic       cas_oe;
    logic       vec_oe;
    logic [1:0] vec_phase;
    logic       selected;
    logic       ack_done;
    logic       seq_err;

    int totalChecks  = 0;
    int passedChecks = 0;

    always #5 clk = ~clk;

    cascade_sequencer #(
        .CAS_W     (3),
        .TO_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sp_en       (sp_en),
        .icw3        (icw3),
        .mode_8086   (mode_8086),
        .int_pending (int_pending),
        .ack_ir      (ack_ir),
        .inta_n      (inta_n),
        .cas_i       (cas_i),
        .cas_o       (cas_o),
        .cas_oe      (cas_oe),
        .vec_oe      (vec_oe),
        .vec_phase   (vec_phase),
        .selected    (selected),
        .ack_done    (ack_done),
        .seq_err     (seq_err)
    );

    // Advance n clocks and land 1 unit past the last rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive INTA to a level and wait for the registered response.
    task automatic applyStimulus(input logic intaVal, input int cycles);
        inta_n = intaVal;
        tick(cycles);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        totalChecks++;
        assert (observed === expected) passedChecks++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".cas_o"},     8'(cas_o),     8'h0);
        checkOutput({tag, ".cas_oe"},    8'(cas_oe),    8'h0);
        checkOutput({tag, ".vec_oe"},    8'(vec_oe),    8'h0);
        checkOutput({tag, ".vec_phase"}, 8'(vec_phase), 8'h0);
        checkOutput({tag, ".selected"},  8'(selected),  8'h0);
    endtask

    initial begin
        rst_n       = 1'b0;
        sp_en       = 1'b1;
        icw3        = 8'h00;
        mode_8086   = 1'b1;
        int_pending = 1'b1;
        ack_ir      = 3'd5;
        inta_n      = 1'b1;
        cas_i       = 3'd0;
        tick(3);
        checkIdle("reset");
        checkOutput("reset.ack_done", 8'(ack_done), 8'h0);
        checkOutput("reset.seq_err",  8'(seq_err),  8'h0);
        rst_n = 1'b1;
        tick(2);

        // 1: master, 8086, no slave on IR5 -> master supplies vector in P2
        $display("[TB] test 1: master 8086 non-cascaded");
        applyStimulus(1'b0, 1);
        checkOutput("t1.p1.cas_oe", 8'(cas_oe), 8'h0);
        checkOutput("t1.p1.vec_oe", 8'(vec_oe), 8'h0);
        tick(2);
        checkOutput("t1.p1.hold.vec_oe", 8'(vec_oe), 8'h0);
        mode_8086 = 1'b0;
        applyStimulus(1'b1, 1);
        checkOutput("t1.r1.ack_done", 8'(ack_done), 8'h0);
        applyStimulus(1'b0, 1);
        checkOutput("t1.p2.vec_oe",    8'(vec_oe),    8'h1);
        checkOutput("t1.p2.vec_phase", 8'(vec_phase), 8'h1);
        checkOutput("t1.p2.cas_oe",    8'(cas_oe),    8'h0);
        applyStimulus(1'b1, 1);
        checkOutput("t1.r2.ack_done", 8'(ack_done), 8'h1);
        checkIdle("t1.end");
        tick(1);
        checkOutput("t1.ack_pulse", 8'(ack_done), 8'h0);

        // 2: master, 8080, slave on IR5 -> CAS=5, master only sends CALL
        $display("[TB] test 2: master 8080 cascaded");
        icw3 = 8'h20; mode_8086 = 1'b0; ack_ir = 3'd5;
        applyStimulus(1'b0, 1);
        checkOutput("t2.p1.cas_o",     8'(cas_o),     8'h5);
        checkOutput("t2.p1.cas_oe",    8'(cas_oe),    8'h1);
        checkOutput("t2.p1.vec_oe",    8'(vec_oe),    8'h1);
        checkOutput("t2.p1.vec_phase", 8'(vec_phase), 8'h0);
        ack_ir = 3'd3; sp_en = 1'b0;
        applyStimulus(1'b1, 1);
        checkOutput("t2.r1.vec_oe", 8'(vec_oe), 8'h0);
        checkOutput("t2.r1.cas_oe", 8'(cas_oe), 8'h1);
        applyStimulus(1'b0, 1);
        checkOutput("t2.p2.vec_phase", 8'(vec_phase), 8'h1);
        checkOutput("t2.p2.vec_oe",    8'(vec_oe),    8'h0);
        checkOutput("t2.p2.cas_o",     8'(cas_o),     8'h5);
        applyStimulus(1'b1, 1);
        checkOutput("t2.r2.ack_done", 8'(ack_done), 8'h0);
        applyStimulus(1'b0, 1);
        checkOutput("t2.p3.vec_phase", 8'(vec_phase), 8'h2);
        checkOutput("t2.p3.vec_oe",    8'(vec_oe),    8'h0);
        checkOutput("t2.p3.cas_oe",    8'(cas_oe),    8'h1);
        applyStimulus(1'b1, 1);
        checkOutput("t2.r3.ack_done", 8'(ack_done), 8'h1);
        checkIdle("t2.end");
        tick(1);

        // 3a: slave ID 2, CAS = 2 -> selected, drives P2/P3
        $display("[TB] test 3: slave decode");
        sp_en = 1'b0; icw3 = 8'h02; cas_i = 3'd2;
        applyStimulus(1'b0, 1);
        checkOutput("t3a.p1.selected", 8'(selected), 8'h1);
        checkOutput("t3a.p1.vec_oe",   8'(vec_oe),   8'h0);
        checkOutput("t3a.p1.cas_oe",   8'(cas_oe),   8'h0);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 1);
        checkOutput("t3a.p2.vec_oe",    8'(vec_oe),    8'h1);
        checkOutput("t3a.p2.vec_phase", 8'(vec_phase), 8'h1);
        applyStimulus(1'b1, 1);
        checkOutput("t3a.r2.vec_oe", 8'(vec_oe), 8'h0);
        applyStimulus(1'b0, 1);
        checkOutput("t3a.p3.vec_oe",    8'(vec_oe),    8'h1);
        checkOutput("t3a.p3.vec_phase", 8'(vec_phase), 8'h2);
        applyStimulus(1'b1, 1);
        checkOutput("t3a.r3.ack_done", 8'(ack_done), 8'h1);
        checkIdle("t3a.end");
        tick(1);

        // 3b: CAS = 3 does not match ID 2 -> silent slave
        cas_i = 3'd3;
        applyStimulus(1'b0, 1);
        checkOutput("t3b.p1.selected", 8'(selected), 8'h0);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 1);
        checkOutput("t3b.p2.vec_oe", 8'(vec_oe), 8'h0);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 1);
        checkOutput("t3b.p3.vec_oe", 8'(vec_oe), 8'h0);
        applyStimulus(1'b1, 1);
        checkOutput("t3b.r3.ack_done", 8'(ack_done), 8'h1);
        tick(1);

        // 4: spurious acknowledge on a master with a slave on IR7
        $display("[TB] test 4: spurious acknowledge");
        sp_en = 1'b1; icw3 = 8'h80; int_pending = 1'b0; ack_ir = 3'd2;
        applyStimulus(1'b0, 1);
        checkOutput("t4.p1.cas_o",  8'(cas_o),  8'h7);
        checkOutput("t4.p1.cas_oe", 8'(cas_oe), 8'h1);
        checkOutput("t4.p1.vec_oe", 8'(vec_oe), 8'h1);
        int_pending = 1'b1;
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 1);
        checkOutput("t4.p2.vec_oe", 8'(vec_oe), 8'h0);
        checkOutput("t4.p2.cas_o",  8'(cas_o),  8'h7);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 1);
        checkOutput("t4.r3.ack_done", 8'(ack_done), 8'h1);
        tick(1);

        // 5: reset during P2, then a clean sequence
        $display("[TB] test 5: reset mid-sequence");
        icw3 = 8'h20; ack_ir = 3'd5; mode_8086 = 1'b0;
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 1);
        checkOutput("t5.p2.cas_oe", 8'(cas_oe), 8'h1);
        rst_n = 1'b0; inta_n = 1'b1;
        #1;
        checkIdle("t5.async");
        tick(1);
        checkIdle("t5.reset");
        checkOutput("t5.reset.ack_done", 8'(ack_done), 8'h0);
        rst_n = 1'b1;
        tick(1);
        checkOutput("t5.release.ack_done", 8'(ack_done), 8'h0);
        applyStimulus(1'b0, 1);
        checkOutput("t5.new.cas_o",  8'(cas_o),  8'h5);
        checkOutput("t5.new.vec_oe", 8'(vec_oe), 8'h1);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 1);
        checkOutput("t5.new.ack_done", 8'(ack_done), 8'h1);
        tick(1);

`ifdef CASCADE_TIMEOUT_EN
        // 6: INTA stuck low after the first fall -> abort after 16 cycles
        $display("[TB] test 6: timeout");
        applyStimulus(1'b0, 1);
        checkOutput("t6.p1.cas_oe", 8'(cas_oe), 8'h1);
        tick(15);
        checkOutput("t6.before.seq_err", 8'(seq_err), 8'h0);
        checkOutput("t6.before.cas_oe",  8'(cas_oe),  8'h1);
        tick(1);
        checkOutput("t6.abort.seq_err", 8'(seq_err), 8'h1);
        checkIdle("t6.abort");
        checkOutput("t6.abort.ack_done", 8'(ack_done), 8'h0);
        tick(1);
        checkOutput("t6.pulse.seq_err", 8'(seq_err), 8'h0);
        applyStimulus(1'b1, 1);
        checkOutput("t6.rise.ack_done", 8'(ack_done), 8'h0);
        tick(1);
`endif

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
